// File: rtl/core_bus_sched_pkg.sv
// Shared types for the core bus scheduler: address/data words, owner and FSM encodings.
// Latency: n/a (types and pure helpers only).
// Backpressure: n/a.
package core_bus_sched_pkg;

  typedef logic [29:0] ptr;
  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    OWN_INSN,
    OWN_DATA,
    OWN_DBG
  } bus_owner;

  typedef enum logic {
    BUS_IDLE,
    BUS_BUSY
  } bus_sched_state;

  // One latched request as it will appear on the bus pins.
  typedef struct packed {
    ptr         addr;
    logic       write;
    word        data_wr;
    logic [3:0] data_be;
  } bus_req_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Reads always present full byte enables on the bus.
  function automatic logic [3:0] bus_be(input bus_req_t r);
    return r.write ? r.data_be : BE_ALL;
  endfunction

endpackage

// File: rtl/core_bus_sched_port.sv
// One requester slot: pending flag plus field latch, with a same-cycle bypass of a new start.
// Latency: a start is visible on req in the cycle it is asserted (combinational bypass).
// Backpressure: a start while pending is dropped unless the slot completes that cycle.
module core_bus_sched_port
  import core_bus_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  bus_req_t fields,
  input  logic     done,
  output logic     req,
  output bus_req_t req_fields
);

  logic     pend;
  bus_req_t lat;
  logic     accept;

  // A completing slot may take a new request in the same cycle (set beats clear).
  assign accept     = start & (~pend | done);
  assign req        = accept | (pend & ~done);
  assign req_fields = accept ? fields : lat;

  // Pending flag and field latch; fields only move when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      lat  <= '0;
    end else if (accept) begin
      pend <= 1'b1;
      lat  <= fields;
    end else if (done) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/core_bus_sched.sv
// Three-way scheduler (dbg > data > insn, with insn anti-starvation) for the single external bus.
// Latency: bus_start the cycle after X_start; next bus_start the cycle after bus_ready.
// Backpressure: one request held per port; repeat starts while pending are dropped.
module core_bus_sched
  import core_bus_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        insn_start,
  input  logic [29:0] insn_addr,
  output logic        insn_ready,
  output logic [31:0] insn_data_rd,
  input  logic        data_start,
  input  logic [29:0] data_addr,
  input  logic        data_write,
  input  logic [31:0] data_data_wr,
  input  logic [3:0]  data_data_be,
  output logic        data_ready,
  output logic [31:0] data_data_rd,
  input  logic        dbg_start,
  input  logic [29:0] dbg_addr,
  input  logic        dbg_write,
  input  logic [31:0] dbg_data_wr,
  input  logic [3:0]  dbg_data_be,
  output logic        dbg_ready,
  output logic [31:0] dbg_data_rd,
  input  logic        halted,
  output logic [29:0] bus_addr,
  output logic        bus_start,
  output logic        bus_write,
  output logic [31:0] bus_data_wr,
  output logic [3:0]  bus_data_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_data_rd
);

  bus_sched_state   state, state_nxt;
  bus_owner         owner, winner;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant, can_arb, insn_ok, starved, busy_done;
  logic             insn_req, data_req, dbg_req;
  bus_req_t         insn_in, data_in, dbg_in;
  bus_req_t         insn_f, data_f, dbg_f, sel;

  assign insn_in = '{addr: insn_addr, write: 1'b0, data_wr: '0, data_be: BE_ALL};
  assign data_in = '{addr: data_addr, write: data_write, data_wr: data_data_wr, data_be: data_data_be};
  assign dbg_in  = '{addr: dbg_addr, write: dbg_write, data_wr: dbg_data_wr, data_be: dbg_data_be};

  // Completion is only meaningful while a transaction is outstanding; stray bus_ready is ignored.
  assign busy_done  = ~rst & bus_ready & (state == BUS_BUSY);
  assign insn_ready = busy_done & (owner == OWN_INSN);
  assign data_ready = busy_done & (owner == OWN_DATA);
  assign dbg_ready  = busy_done & (owner == OWN_DBG);

  assign insn_data_rd = bus_data_rd;
  assign data_data_rd = bus_data_rd;
  assign dbg_data_rd  = bus_data_rd;

  core_bus_sched_port u_insn (
    .clk(clk), .rst(rst), .start(insn_start), .fields(insn_in), .done(insn_ready),
    .req(insn_req), .req_fields(insn_f)
  );
  core_bus_sched_port u_data (
    .clk(clk), .rst(rst), .start(data_start), .fields(data_in), .done(data_ready),
    .req(data_req), .req_fields(data_f)
  );
  core_bus_sched_port u_dbg (
    .clk(clk), .rst(rst), .start(dbg_start), .fields(dbg_in), .done(dbg_ready),
    .req(dbg_req), .req_fields(dbg_f)
  );

  // Arbitrate when idle, or on the completing edge so back-to-back grants lose no cycle.
  assign can_arb = (state == BUS_IDLE) | busy_done;
  assign insn_ok = insn_req & ~halted;
  assign starved = insn_ok & (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= BUS_IDLE;
    else     state <= state_nxt;
  end

  // Next state and winner selection; the starved insn request outranks everything.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = OWN_INSN;
    if (can_arb) begin
      state_nxt = BUS_IDLE;
      if (starved) begin
        grant  = 1'b1;
        winner = OWN_INSN;
      end else if (dbg_req) begin
        grant  = 1'b1;
        winner = OWN_DBG;
      end else if (data_req) begin
        grant  = 1'b1;
        winner = OWN_DATA;
      end else if (insn_ok) begin
        grant  = 1'b1;
        winner = OWN_INSN;
      end
      if (grant) state_nxt = BUS_BUSY;
    end
  end

  // Field mux for the winning port.
  always_comb begin
    sel = insn_f;
    case (winner)
      OWN_DATA: sel = data_f;
      OWN_DBG:  sel = dbg_f;
      default:  sel = insn_f;
    endcase
  end

  // Bus pins, owner and starvation counter; pins hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_INSN;
      bus_start   <= 1'b0;
      bus_addr    <= '0;
      bus_write   <= 1'b0;
      bus_data_wr <= '0;
      bus_data_be <= '0;
      starve_cnt  <= '0;
    end else begin
      bus_start <= grant;
      if (grant) begin
        owner       <= winner;
        bus_addr    <= sel.addr;
        bus_write   <= sel.write;
        bus_data_wr <= sel.data_wr;
        bus_data_be <= bus_be(sel);
        if (winner == OWN_INSN || !insn_req)
          starve_cnt <= '0;
        else if (starve_cnt != {CNT_W{1'b1}})
          starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (!insn_req) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule
